disp_scan_ctrl: RTL and testbench

Sequencer for the 8-digit BCD display mux: generates the 3-bit digit select (refresh counter) and active-low anode enables.
Inserts an all-anodes-off dead time at each digit change to stop ghosting.
Takes a tear-free snapshot of the clock/alarm BCD words once per frame, for the mux to select from.
Applies per-digit blink blanking for time/alarm edit modes. Sits between the timekeeping/alarm registers and the BCD mux / 7-segment decoder.

---
 rtl/disp_scan_ctrl_pkg.sv | 22 ++
 rtl/disp_scan_ctrl_scan_prescaler.sv | 39 +++
 rtl/disp_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants, state encoding and anode helper for the 8-digit display scanner.
package disp_scan_ctrl_pkg;

    localparam int NUM_DIGITS     = 8;
    localparam int RC_W           = $clog2(NUM_DIGITS);
    localparam int FIELD_DIGITS   = 4;
    localparam int ALARM_DIGIT_LO = 0;
    localparam int CLOCK_DIGIT_LO = 4;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_DEAD = 2'd1,
        ST_ON   = 2'd2
    } scan_state_e;

    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [RC_W-1:0] digit);
        anode_for = ~(NUM_DIGITS'(1) << digit);
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_scan_prescaler.sv
// Digit-slot counter: counts 0..PRESCALE-1, flags the last dead-time cycle and the last slot cycle.
module disp_scan_ctrl_scan_prescaler #(
    parameter int PRESCALE = 100000,
    parameter int DEAD_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic dead_end,
    output logic slot_end
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign dead_end = en && (cnt_q == CW'(DEAD_CYC - 1));
    assign slot_end = en && (cnt_q == CW'(PRESCALE - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = slot_end ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Display scan sequencer: digit select, dead-time anode blanking, per-frame BCD snapshots
// and blink blanking for the edit modes.
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int PRESCALE     = 100000,
    parameter int DEAD_CYC     = 1000,
    parameter int BLINK_FRAMES = 62
) (
    input  logic                  disp_scan_ctrl_clk,
    input  logic                  disp_scan_ctrl_rst_n,
    input  logic                  disp_scan_ctrl_en,
    input  logic [NUM_DIGITS-1:0] disp_scan_ctrl_blink_mask,
    input  logic [15:0]           disp_scan_ctrl_clock_in,
    input  logic [15:0]           disp_scan_ctrl_alarm_in,
    output logic [RC_W-1:0]       disp_scan_ctrl_rc,
    output logic [15:0]           disp_scan_ctrl_clock_snap,
    output logic [15:0]           disp_scan_ctrl_alarm_snap,
    output logic [NUM_DIGITS-1:0] disp_scan_ctrl_an,
    output logic                  disp_scan_ctrl_frame_start
);

    localparam int FW = $clog2(BLINK_FRAMES + 1);

    scan_state_e           state_q, state_d;
    logic [RC_W-1:0]       rc_q, rc_d;
    logic [15:0]           clock_snap_q, clock_snap_d;
    logic [15:0]           alarm_snap_q, alarm_snap_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_start_q, frame_start_d;
    logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
    logic                  blink_phase_q, blink_phase_d;

    logic                  dead_end;
    logic                  slot_end;
    logic [NUM_DIGITS-1:0] blink_sel;
    logic [NUM_DIGITS-1:0] digit_blank;

    disp_scan_ctrl_scan_prescaler #(
        .PRESCALE (PRESCALE),
        .DEAD_CYC (DEAD_CYC)
    ) u_prescaler (
        .clk      (disp_scan_ctrl_clk),
        .rst_n    (disp_scan_ctrl_rst_n),
        .clr      (!disp_scan_ctrl_en || (state_q == ST_OFF)),
        .en       (state_q != ST_OFF),
        .dead_end (dead_end),
        .slot_end (slot_end)
    );

    // Mask layout: alarm digits in the low field, clock digits in the high field.
    assign blink_sel[ALARM_DIGIT_LO +: FIELD_DIGITS] = disp_scan_ctrl_blink_mask[ALARM_DIGIT_LO +: FIELD_DIGITS];
    assign blink_sel[CLOCK_DIGIT_LO +: FIELD_DIGITS] = disp_scan_ctrl_blink_mask[CLOCK_DIGIT_LO +: FIELD_DIGITS];

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
            assign digit_blank[gi] = blink_sel[gi] & blink_phase_d;
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        rc_d          = rc_q;
        clock_snap_d  = clock_snap_q;
        alarm_snap_d  = alarm_snap_q;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!disp_scan_ctrl_en) begin
            state_d       = ST_OFF;
            rc_d          = '0;
            frame_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d       = ST_DEAD;
                    rc_d          = '0;
                    clock_snap_d  = disp_scan_ctrl_clock_in;
                    alarm_snap_d  = disp_scan_ctrl_alarm_in;
                    frame_start_d = 1'b1;
                    frame_cnt_d   = '0;
                    blink_phase_d = 1'b0;
                end
                ST_DEAD: begin
                    if (dead_end) state_d = ST_ON;
                end
                ST_ON: begin
                    if (slot_end) begin
                        state_d = ST_DEAD;
                        if (rc_q == RC_W'(NUM_DIGITS - 1)) begin
                            rc_d          = '0;
                            clock_snap_d  = disp_scan_ctrl_clock_in;
                            alarm_snap_d  = disp_scan_ctrl_alarm_in;
                            frame_start_d = 1'b1;
                            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                                frame_cnt_d   = '0;
                                blink_phase_d = ~blink_phase_q;
                            end else begin
                                frame_cnt_d = frame_cnt_q + FW'(1);
                            end
                        end else begin
                            rc_d = rc_q + RC_W'(1);
                        end
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Anodes follow the next-cycle state so the pins line up with rc and the slot counter.
    always_comb begin
        an_d = ANODE_OFF;
        if ((state_d == ST_ON) && !digit_blank[rc_d]) begin
            an_d = anode_for(rc_d);
        end
    end

    always_ff @(posedge disp_scan_ctrl_clk or negedge disp_scan_ctrl_rst_n) begin
        if (!disp_scan_ctrl_rst_n) begin
            state_q       <= ST_OFF;
            rc_q          <= '0;
            clock_snap_q  <= '0;
            alarm_snap_q  <= '0;
            an_q          <= ANODE_OFF;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rc_q          <= rc_d;
            clock_snap_q  <= clock_snap_d;
            alarm_snap_q  <= alarm_snap_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign disp_scan_ctrl_rc          = rc_q;
    assign disp_scan_ctrl_clock_snap  = clock_snap_q;
    assign disp_scan_ctrl_alarm_snap  = alarm_snap_q;
    assign disp_scan_ctrl_an          = an_q;
    assign disp_scan_ctrl_frame_start = frame_start_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with PRESCALE=4, DEAD_CYC=1, BLINK_FRAMES=2.
module tb_disp_scan_ctrl;

    localparam int NV = 160;

    typedef struct {
        logic        en;
        logic [7:0]  mask;
        logic [15:0] cin;
        logic [15:0] ain;
        logic [2:0]  rc;
        logic [7:0]  an;
        logic        fs;
        logic [15:0] csnap;
        logic [15:0] asnap;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b1;
    logic [7:0]  mask  = 8'hF0;
    logic [15:0] cin   = 16'h1234;
    logic [15:0] ain   = 16'h0630;
    logic [2:0]  rc;
    logic [15:0] csnap;
    logic [15:0] asnap;
    logic [7:0]  an;
    logic        fs;

    int total = 0;
    int bad   = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    disp_scan_ctrl #(
        .PRESCALE     (4),
        .DEAD_CYC     (1),
        .BLINK_FRAMES (2)
    ) dut (
        .disp_scan_ctrl_clk         (clk),
        .disp_scan_ctrl_rst_n       (rst_n),
        .disp_scan_ctrl_en          (en),
        .disp_scan_ctrl_blink_mask  (mask),
        .disp_scan_ctrl_clock_in    (cin),
        .disp_scan_ctrl_alarm_in    (ain),
        .disp_scan_ctrl_rc          (rc),
        .disp_scan_ctrl_clock_snap  (csnap),
        .disp_scan_ctrl_alarm_snap  (asnap),
        .disp_scan_ctrl_an          (an),
        .disp_scan_ctrl_frame_start (fs)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            en   = vecs[i].en;
            mask = vecs[i].mask;
            cin  = vecs[i].cin;
            ain  = vecs[i].ain;
            cycle();
            $display("vec %0d rc=%0d an=%h fs=%0d csnap=%h asnap=%h", i, rc, an, fs, csnap, asnap);
            chk($sformatf("v%0d_rc", i), 32'(rc), 32'(vecs[i].rc));
            chk($sformatf("v%0d_an", i), 32'(an), 32'(vecs[i].an));
            chk($sformatf("v%0d_fs", i), 32'(fs), 32'(vecs[i].fs));
            chk($sformatf("v%0d_csnap", i), 32'(csnap), 32'(vecs[i].csnap));
            chk($sformatf("v%0d_asnap", i), 32'(asnap), 32'(vecs[i].asnap));
            chk($sformatf("v%0d_onehot", i), 32'($countones(~an) <= 1), 32'd1);
        end
    endtask

    initial begin
        int found;
        int fs_seen;
        logic [7:0] one;

        // Cycle k: slot k/4, slot position k%4 (0 = dead), frame k/32, blink phase (frame/2)%2.
        one = 8'h01;
        for (int k = 0; k < NV; k++) begin
            int f;
            int s;
            int p;
            int ph;
            f  = k / 32;
            s  = (k % 32) / 4;
            p  = k % 4;
            ph = (f / 2) % 2;
            vecs[k].en    = 1'b1;
            vecs[k].mask  = 8'hF0;
            vecs[k].cin   = (k < 10) ? 16'h1234 : 16'h1235;
            vecs[k].ain   = (k < 40) ? 16'h0630 : 16'h0745;
            vecs[k].rc    = 3'(s);
            vecs[k].an    = ((p != 0) && !((ph == 1) && (s >= 4))) ? ~(one << s) : 8'hFF;
            vecs[k].fs    = (k % 32 == 0);
            vecs[k].csnap = (f == 0) ? 16'h1234 : 16'h1235;
            vecs[k].asnap = (f < 2) ? 16'h0630 : 16'h0745;
        end

        // Reset held with en=1 and live inputs present.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_rc", 32'(rc), 32'd0);
        chk("rst_fs", 32'(fs), 32'd0);
        chk("rst_csnap", 32'(csnap), 32'd0);
        chk("rst_asnap", 32'(asnap), 32'd0);
        rst_n = 1'b1;

        // First frame, free run, mid-frame input change, blink over five frames.
        run_vectors(0, NV - 1);

        // Drop enable while digit 5 is lit.
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            cycle();
            if (rc == 3'd5 && an == 8'hDF) found = 1;
        end
        chk("wait_rc5_on", 32'(found), 32'd1);
        en = 1'b0;
        cycle();
        $display("en_drop rc=%0d an=%h fs=%0d", rc, an, fs);
        chk("off_an", 32'(an), 32'hFF);
        chk("off_rc", 32'(rc), 32'd0);
        chk("off_fs", 32'(fs), 32'd0);
        chk("off_csnap_held", 32'(csnap), 32'h1235);
        chk("off_asnap_held", 32'(asnap), 32'h0745);
        repeat (3) cycle();
        chk("off_an_stays", 32'(an), 32'hFF);
        chk("off_fs_stays", 32'(fs), 32'd0);

        // Re-enable: fresh snapshot, digit 0, dead slot first.
        cin = 16'h0959;
        ain = 16'h0101;
        en  = 1'b1;
        cycle();
        $display("reenable rc=%0d an=%h fs=%0d csnap=%h", rc, an, fs, csnap);
        chk("reen_fs", 32'(fs), 32'd1);
        chk("reen_rc", 32'(rc), 32'd0);
        chk("reen_an", 32'(an), 32'hFF);
        chk("reen_csnap", 32'(csnap), 32'h0959);
        chk("reen_asnap", 32'(asnap), 32'h0101);
        cycle();
        chk("reen_an_on", 32'(an), 32'hFE);
        chk("reen_fs_low", 32'(fs), 32'd0);

        // Advance into frame 2 (blink phase 1), then reset asynchronously while digit 3 is lit.
        fs_seen = 0;
        for (int i = 0; i < 100 && fs_seen < 2; i++) begin
            cycle();
            if (fs) fs_seen++;
        end
        chk("wait_frame2", 32'(fs_seen), 32'd2);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            cycle();
            if (an == 8'hF7) found = 1;
        end
        chk("wait_an_f7", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        $display("async_reset rc=%0d an=%h fs=%0d", rc, an, fs);
        chk("arst_an", 32'(an), 32'hFF);
        chk("arst_rc", 32'(rc), 32'd0);
        chk("arst_fs", 32'(fs), 32'd0);
        chk("arst_csnap", 32'(csnap), 32'd0);
        chk("arst_asnap", 32'(asnap), 32'd0);
        cycle();
        chk("arst_an_hold", 32'(an), 32'hFF);
        rst_n = 1'b1;

        // First frame again; digits 4-7 must light, so blink phase was cleared.
        run_vectors(0, 31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
